// File: rtl/tri_tlb_responder.sv
// Responder end of the TRI translator TLB query handshake.
// Query: requester raises tlb_valid with a stable tlb_vpn and holds it until it
// sees tlb_ack. The ack is a registered one-cycle pulse that qualifies
// tlb_ppn/tlb_fault. Walk requests use valid/ready: ptw_req_valid/ptw_req_vpn
// stay stable until ptw_req_ready is seen high on a clock edge. A walk response
// is a single-cycle ptw_resp_valid pulse with no back-pressure.
// The current FSM state is exported on dbg_state for checkers.
module tri_tlb_responder #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 52,
  parameter int PPN_W   = 52,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlb_valid,
  input  logic [VPN_W-1:0] tlb_vpn,
  output logic             tlb_ack,
  output logic [PPN_W-1:0] tlb_ppn,
  output logic             tlb_fault,
  input  logic             tlb_flush,
  output logic             ptw_req_valid,
  input  logic             ptw_req_ready,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn,
  input  logic             ptw_resp_fault,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [2:0]       dbg_state
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WALK   = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t             state;
  logic [VPN_W-1:0]   vpn_r;
  logic               no_fill_r;   // a flush hit this walk, so its result must not be installed

  logic [ENTRIES-1:0] ent_valid;
  logic [VPN_W-1:0]   ent_vpn [ENTRIES];
  logic [PPN_W-1:0]   ent_ppn [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               inv_found;
  logic [IDX_W-1:0]   victim_idx;
  logic               fill_en;

  assign dbg_state = state;

  // Fully associative compare of the latched VPN; at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && ent_valid[i] && (ent_vpn[i] == vpn_r)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim: lowest-index invalid entry, else the round-robin pointer.
  always_comb begin
    inv_found  = 1'b0;
    victim_idx = rr_ptr;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!inv_found && !ent_valid[i]) begin
        inv_found  = 1'b1;
        victim_idx = IDX_W'(i);
      end
    end
  end

  // Install only good walk results that no flush has overtaken.
  assign fill_en = (state == S_WAIT) && ptw_resp_valid && !ptw_resp_fault &&
                   !no_fill_r && !tlb_flush;

  // Entry valid bits and replacement pointer; flush takes priority over a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (tlb_flush) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (fill_en) begin
      ent_valid[victim_idx] <= 1'b1;
      rr_ptr                <= rr_ptr + IDX_W'(1);
    end
  end

  // Entry payload storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      ent_vpn[victim_idx] <= vpn_r;
      ent_ppn[victim_idx] <= ptw_resp_ppn;
    end
  end

  // Query FSM with registered handshake outputs and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      vpn_r         <= '0;
      no_fill_r     <= 1'b0;
      tlb_ack       <= 1'b0;
      tlb_ppn       <= '0;
      tlb_fault     <= 1'b0;
      ptw_req_valid <= 1'b0;
      ptw_req_vpn   <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      tlb_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tlb_valid) begin
            vpn_r     <= tlb_vpn;
            no_fill_r <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            tlb_ppn   <= ent_ppn[hit_idx];
            tlb_fault <= 1'b0;
            tlb_ack   <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            state     <= S_RESP;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            ptw_req_valid <= 1'b1;
            ptw_req_vpn   <= vpn_r;
            state         <= S_WALK;
          end
        end
        S_WALK: begin
          if (tlb_flush) no_fill_r <= 1'b1;
          if (ptw_req_ready) begin
            ptw_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tlb_flush) no_fill_r <= 1'b1;
          if (ptw_resp_valid) begin
            tlb_ppn   <= ptw_resp_fault ? '0 : ptw_resp_ppn;
            tlb_fault <= ptw_resp_fault;
            tlb_ack   <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_tlb_responder.sv
// Directed bench for tri_tlb_responder: cold miss, hit latency, eviction,
// walk fault, flush during walk, stalled walker and reset mid-walk.
module tb_tri_tlb_responder;

  localparam int VPN_W = 52;
  localparam int PPN_W = 52;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             tlb_valid;
  logic [VPN_W-1:0] tlb_vpn;
  logic             tlb_ack;
  logic [PPN_W-1:0] tlb_ppn;
  logic             tlb_fault;
  logic             tlb_flush;
  logic             ptw_req_valid;
  logic             ptw_req_ready;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_resp_valid;
  logic [PPN_W-1:0] ptw_resp_ppn;
  logic             ptw_resp_fault;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [2:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  tri_tlb_responder #(.ENTRIES(8), .VPN_W(VPN_W), .PPN_W(PPN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .tlb_valid(tlb_valid), .tlb_vpn(tlb_vpn),
    .tlb_ack(tlb_ack), .tlb_ppn(tlb_ppn), .tlb_fault(tlb_fault),
    .tlb_flush(tlb_flush),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_fault(ptw_resp_fault),
    .hit_count(hit_count), .miss_count(miss_count),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: issue one query and act as the walker. Cycle 0 is the first
  // cycle tlb_valid is high; ack_cyc is the cycle the ack was seen (-1 = none).
  task automatic run_query(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] rppn,
                           input logic rfault, input bit flush_in_wait,
                           output int ack_cyc, output logic [PPN_W-1:0] ppn,
                           output logic flt, output int nreq, output logic [VPN_W-1:0] rvpn);
    int phase;
    ack_cyc = -1; ppn = '0; flt = 1'b0; nreq = 0; rvpn = '0; phase = 0;
    @(negedge clk);
    tlb_vpn   = vpn;
    tlb_valid = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (phase == 2) begin
        ptw_resp_valid = 1'b0;
        tlb_flush      = 1'b0;
        phase          = 3;
      end
      if (tlb_ack) begin
        ack_cyc   = k;
        ppn       = tlb_ppn;
        flt       = tlb_fault;
        tlb_valid = 1'b0;
        break;
      end
      if (phase == 0 && ptw_req_valid) begin
        nreq++;
        rvpn  = ptw_req_vpn;
        phase = 1;
      end else if (phase == 1) begin
        ptw_resp_valid = 1'b1;
        ptw_resp_ppn   = rppn;
        ptw_resp_fault = rfault;
        tlb_flush      = flush_in_wait;
        phase          = 2;
      end
    end
    tlb_valid      = 1'b0;
    ptw_resp_valid = 1'b0;
    tlb_flush      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn   = 52'h3333;
    repeat (3) @(negedge clk);
    checks++; if (tlb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", tlb_ack); end
    checks++; if (tlb_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", tlb_fault); end
    checks++; if (tlb_ppn !== '0) begin failures++; $display("FAIL reset_ppn got=%0h exp=0", tlb_ppn); end
    checks++; if (ptw_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", ptw_req_valid); end
    checks++; if (ptw_req_vpn !== '0) begin failures++; $display("FAIL reset_req_vpn got=%0h exp=0", ptw_req_vpn); end
    checks++; if (hit_count !== '0) begin failures++; $display("FAIL reset_hit got=%0d exp=0", hit_count); end
    checks++; if (miss_count !== '0) begin failures++; $display("FAIL reset_miss got=%0d exp=0", miss_count); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    // A stale walk response right after reset must be ignored.
    rst = 1'b0;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (tlb_ack !== 1'b0) begin failures++; $display("FAIL stale_resp_ack got=%0b exp=0", tlb_ack); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL stale_resp_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_cold_miss();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    run_query(52'h12345, 52'hABCDE, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL cold_nreq got=%0d exp=1", nr); end
    checks++; if (rv !== 52'h12345) begin failures++; $display("FAIL cold_req_vpn got=%0h exp=12345", rv); end
    checks++; if (ac !== 4) begin failures++; $display("FAIL cold_latency got=%0d exp=4", ac); end
    checks++; if (p !== 52'hABCDE) begin failures++; $display("FAIL cold_ppn got=%0h exp=abcde", p); end
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL cold_fault got=%0b exp=0", f); end
    checks++; if (miss_count !== CNT_W'(exp_miss)) begin failures++; $display("FAIL cold_miss_cnt got=%0d exp=%0d", miss_count, exp_miss); end
    checks++; if (hit_count !== CNT_W'(exp_hit)) begin failures++; $display("FAIL cold_hit_cnt got=%0d exp=%0d", hit_count, exp_hit); end
  endtask

  task automatic test_hit();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    run_query(52'h12345, 52'h0, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_hit++;
    checks++; if (ac !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", ac); end
    checks++; if (nr !== 0) begin failures++; $display("FAIL hit_nreq got=%0d exp=0", nr); end
    checks++; if (p !== 52'hABCDE) begin failures++; $display("FAIL hit_ppn got=%0h exp=abcde", p); end
    checks++; if (hit_count !== CNT_W'(exp_hit)) begin failures++; $display("FAIL hit_cnt got=%0d exp=%0d", hit_count, exp_hit); end
    checks++; if (miss_count !== CNT_W'(exp_miss)) begin failures++; $display("FAIL hit_miss_cnt got=%0d exp=%0d", miss_count, exp_miss); end
  endtask

  task automatic test_fill_evict();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    @(negedge clk); tlb_flush = 1'b1;
    @(negedge clk); tlb_flush = 1'b0;
    for (int v = 0; v < 9; v++) begin
      run_query(VPN_W'(v), PPN_W'(32'h1000 + v), 1'b0, 1'b0, ac, p, f, nr, rv);
      exp_miss++;
      checks++; if (nr !== 1) begin failures++; $display("FAIL fill_nreq vpn=%0d got=%0d exp=1", v, nr); end
    end
    // vpn 0 was evicted by vpn 8; its refill replaces entry 1 (vpn 1).
    run_query(52'h0, 52'h2000, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL evict_vpn0_nreq got=%0d exp=1", nr); end
    checks++; if (p !== 52'h2000) begin failures++; $display("FAIL evict_vpn0_ppn got=%0h exp=2000", p); end
    run_query(52'h8, 52'hdead, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_hit++;
    checks++; if (nr !== 0) begin failures++; $display("FAIL vpn8_nreq got=%0d exp=0", nr); end
    checks++; if (p !== 52'h1008) begin failures++; $display("FAIL vpn8_ppn got=%0h exp=1008", p); end
    run_query(52'h2, 52'hdead, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_hit++;
    checks++; if (nr !== 0) begin failures++; $display("FAIL vpn2_nreq got=%0d exp=0", nr); end
    checks++; if (p !== 52'h1002) begin failures++; $display("FAIL vpn2_ppn got=%0h exp=1002", p); end
    run_query(52'h1, 52'h3001, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL vpn1_evicted_nreq got=%0d exp=1", nr); end
    checks++; if (hit_count !== CNT_W'(exp_hit)) begin failures++; $display("FAIL fill_hit_cnt got=%0d exp=%0d", hit_count, exp_hit); end
    checks++; if (miss_count !== CNT_W'(exp_miss)) begin failures++; $display("FAIL fill_miss_cnt got=%0d exp=%0d", miss_count, exp_miss); end
  endtask

  task automatic test_fault();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    run_query(52'h777, 52'h999, 1'b1, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (f !== 1'b1) begin failures++; $display("FAIL fault_flag got=%0b exp=1", f); end
    checks++; if (p !== '0) begin failures++; $display("FAIL fault_ppn got=%0h exp=0", p); end
    checks++; if (rv !== 52'h777) begin failures++; $display("FAIL fault_req_vpn got=%0h exp=777", rv); end
    run_query(52'h777, 52'h888, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL fault_rewalk_nreq got=%0d exp=1", nr); end
    checks++; if (p !== 52'h888) begin failures++; $display("FAIL fault_rewalk_ppn got=%0h exp=888", p); end
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL fault_rewalk_flag got=%0b exp=0", f); end
  endtask

  task automatic test_flush_wait();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    run_query(52'h55, 52'h5555, 1'b0, 1'b1, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (ac !== 4) begin failures++; $display("FAIL flush_ack_latency got=%0d exp=4", ac); end
    checks++; if (p !== 52'h5555) begin failures++; $display("FAIL flush_ppn got=%0h exp=5555", p); end
    run_query(52'h55, 52'h5556, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL flush_requery_nreq got=%0d exp=1", nr); end
    run_query(52'h8, 52'h1108, 1'b0, 1'b0, ac, p, f, nr, rv);
    exp_miss++;
    checks++; if (nr !== 1) begin failures++; $display("FAIL flush_old_entry_nreq got=%0d exp=1", nr); end
    checks++; if (miss_count !== CNT_W'(exp_miss)) begin failures++; $display("FAIL flush_miss_cnt got=%0d exp=%0d", miss_count, exp_miss); end
  endtask

  task automatic test_stall_reset();
    int ac, nr; logic [PPN_W-1:0] p; logic f; logic [VPN_W-1:0] rv;
    ptw_req_ready = 1'b0;
    @(negedge clk);
    tlb_vpn   = 52'h4242;
    tlb_valid = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++; if (ptw_req_valid !== 1'b1) begin failures++; $display("FAIL stall_req_valid cyc=%0d got=%0b exp=1", k, ptw_req_valid); end
      checks++; if (ptw_req_vpn !== 52'h4242) begin failures++; $display("FAIL stall_req_vpn cyc=%0d got=%0h exp=4242", k, ptw_req_vpn); end
      checks++; if (tlb_ack !== 1'b0) begin failures++; $display("FAIL stall_ack cyc=%0d got=%0b exp=0", k, tlb_ack); end
      @(negedge clk);
    end
    rst       = 1'b1;
    tlb_valid = 1'b0;
    @(negedge clk);
    checks++; if (ptw_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", ptw_req_valid); end
    checks++; if (ptw_req_vpn !== '0) begin failures++; $display("FAIL rst_req_vpn got=%0h exp=0", ptw_req_vpn); end
    checks++; if (tlb_ack !== 1'b0 || tlb_fault !== 1'b0 || tlb_ppn !== '0) begin failures++; $display("FAIL rst_resp got=%0b/%0b/%0h exp=0/0/0", tlb_ack, tlb_fault, tlb_ppn); end
    checks++; if (hit_count !== '0 || miss_count !== '0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst           = 1'b0;
    ptw_req_ready = 1'b1;
    // Reset also invalidated the TLB, so the first translation is cold again.
    run_query(52'h12345, 52'hABCDE, 1'b0, 1'b0, ac, p, f, nr, rv);
    checks++; if (nr !== 1) begin failures++; $display("FAIL post_rst_nreq got=%0d exp=1", nr); end
    checks++; if (miss_count !== CNT_W'(1)) begin failures++; $display("FAIL post_rst_miss got=%0d exp=1", miss_count); end
  endtask

  initial begin
    rst = 1'b1; tlb_valid = 1'b0; tlb_vpn = '0; tlb_flush = 1'b0;
    ptw_req_ready = 1'b1; ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_fault = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_fill_evict();
    test_fault();
    test_flush_wait();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
